// File: rtl/nt_subcircuit_pipe.sv
// nt_subcircuit_pipe
// WIDTH-lane, two-stage valid/ready pipeline of the NAND/NOT trigger
// subcircuit, with a rare-output monitor that raises a sticky alarm after
// THRESH consecutive all-zero output handshakes.
//
// Ports:
//   I1470_clk  - sole clock, all state on the rising edge
//   I1477_rst  - synchronous, active-high reset
//   in_valid   - a/b/c valid this cycle
//   in_ready   - block can accept this cycle (combinational)
//   a, b, c    - lane operands (WIDTH bits each)
//   out_valid  - out holds a result
//   out_ready  - downstream accepts out
//   out        - result lanes (combinational from stage 2)
//   trig_clr   - clears run counter and alarm
//   run_cnt    - current all-zero run length (saturating)
//   trig       - sticky alarm
module nt_subcircuit_pipe #(
    parameter int WIDTH  = 8,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             trig_clr,
    output logic [CNT_W-1:0] run_cnt,
    output logic             trig
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    logic             v1_r;
    logic             v2_r;
    logic [WIDTH-1:0] a1_r;
    logic [WIDTH-1:0] b1_r;
    logic [WIDTH-1:0] c1_r;
    logic [WIDTH-1:0] n2_r;
    logic [WIDTH-1:0] p2_r;
    logic [CNT_W-1:0] run_cnt_r;
    logic             trig_r;

    logic             adv_s;
    logic             out_hs_s;
    logic             out_zero_s;
    logic [WIDTH-1:0] out_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Pipeline advance, output decode and saturating increment.
    always_comb begin
        adv_s      = ~v2_r | out_ready;
        out_s      = ~(n2_r & p2_r);
        out_hs_s   = v2_r & out_ready;
        out_zero_s = (out_s == {WIDTH{1'b0}});
        if (run_cnt_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = run_cnt_r + CNT_W'(1);
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = v2_r;
    assign out       = out_s;
    assign run_cnt   = run_cnt_r;
    assign trig      = trig_r;

    // Two pipeline stages; the whole pipe freezes when the output is stalled.
    // Data registers may capture junk alongside a cleared valid bit.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            a1_r <= {WIDTH{1'b0}};
            b1_r <= {WIDTH{1'b0}};
            c1_r <= {WIDTH{1'b0}};
            n2_r <= {WIDTH{1'b0}};
            p2_r <= {WIDTH{1'b0}};
        end else if (adv_s) begin
            v1_r <= in_valid;
            a1_r <= a;
            b1_r <= b;
            c1_r <= c;
            v2_r <= v1_r;
            n2_r <= ~(b1_r & ~c1_r);
            p2_r <= ~(a1_r & ~b1_r);
        end else begin
            v1_r <= v1_r;
            v2_r <= v2_r;
            a1_r <= a1_r;
            b1_r <= b1_r;
            c1_r <= c1_r;
            n2_r <= n2_r;
            p2_r <= p2_r;
        end
    end

    // Rare-output monitor: only output handshakes move the run counter;
    // a clear wins over a simultaneous handshake, which is then not counted.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            run_cnt_r <= {CNT_W{1'b0}};
            trig_r    <= 1'b0;
        end else if (trig_clr) begin
            run_cnt_r <= {CNT_W{1'b0}};
            trig_r    <= 1'b0;
        end else if (out_hs_s && out_zero_s) begin
            run_cnt_r <= cnt_inc_s;
            if (cnt_inc_s >= THRESH_C) begin
                trig_r <= 1'b1;
            end else begin
                trig_r <= trig_r;
            end
        end else if (out_hs_s) begin
            run_cnt_r <= {CNT_W{1'b0}};
            trig_r    <= trig_r;
        end else begin
            run_cnt_r <= run_cnt_r;
            trig_r    <= trig_r;
        end
    end

endmodule

// File: tb/tb_nt_subcircuit_pipe.sv
module tb_nt_subcircuit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       out_ready;
    logic       trig_clr;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out;
    logic [7:0] run_cnt;
    logic       trig;
    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out2;
    logic [1:0] run_cnt2;
    logic       trig2;

    always #5 clk = ~clk;

    nt_subcircuit_pipe #(.WIDTH(8), .THRESH(4), .CNT_W(8)) dut (
        .I1470_clk(clk), .I1477_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .trig_clr(trig_clr), .run_cnt(run_cnt), .trig(trig)
    );

    // Saturation sweep: 2-bit counter, threshold 3.
    nt_subcircuit_pipe #(.WIDTH(8), .THRESH(3), .CNT_W(2)) dut2 (
        .I1470_clk(clk), .I1477_rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
        .trig_clr(trig_clr), .run_cnt(run_cnt2), .trig(trig2)
    );

    typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] c; logic [7:0] exp; } vec_t;
    typedef struct { logic [7:0] val; int age; } item_t;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    run1 = 0;
    int    run2 = 0;
    bit    trg1 = 1'b0;
    bit    trg2 = 1'b0;
    vec_t  vecs[7];
    logic [7:0] saved;

    // Lane rule: a lane reads 0 exactly when (b=0 or c=1) and (a=0 or b=1).
    function automatic logic [7:0] lane_rule(input logic [7:0] av, input logic [7:0] bv,
                                             input logic [7:0] cv);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = !((!bv[i] || cv[i]) && (!av[i] || bv[i]));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, advance the model, take the edge.
    task automatic cycle();
        bit ov, adv, hs_in, hs_out, zero;
        logic [7:0] hv;
        #1;
        ov  = (q.size() > 0) && (q[0].age == 0);
        hv  = ov ? q[0].val : 8'h00;
        adv = !ov || out_ready;
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("in_ready", 32'(in_ready), 32'(adv));
        chk("run_cnt", 32'(run_cnt), run1);
        chk("trig", 32'(trig), 32'(trg1));
        chk("out_valid2", 32'(out_valid2), 32'(ov));
        chk("run_cnt2", 32'(run_cnt2), run2);
        chk("trig2", 32'(trig2), 32'(trg2));
        if (ov) begin
            chk("out", 32'(out), 32'(hv));
            chk("out2", 32'(out2), 32'(hv));
        end
        hs_out = ov && out_ready;
        hs_in  = in_valid && adv;
        zero   = (hv == 8'h00);
        if (rst) begin
            q.delete();
            run1 = 0; run2 = 0; trg1 = 1'b0; trg2 = 1'b0;
        end else begin
            if (trig_clr) begin
                run1 = 0; run2 = 0; trg1 = 1'b0; trg2 = 1'b0;
            end else if (hs_out && zero) begin
                run1 = (run1 < 255) ? run1 + 1 : 255;
                run2 = (run2 < 3) ? run2 + 1 : 3;
                if (run1 >= 4) trg1 = 1'b1;
                if (run2 >= 3) trg2 = 1'b1;
            end else if (hs_out) begin
                run1 = 0; run2 = 0;
            end
            if (adv) begin
                if (hs_out) void'(q.pop_front());
                foreach (q[i]) if (q[i].age > 0) q[i].age = q[i].age - 1;
                if (hs_in) q.push_back('{val: lane_rule(a, b, c), age: 1});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
        in_valid = 1'b1; a = av; b = bv; c = cv;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
        vecs[6] = '{8'hA5, 8'h0F, 8'hF0, 8'hAF};

        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
        out_ready = 1'b1; trig_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset state while idle
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out", 32'(out), 32'hFF);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_run_cnt", 32'(run_cnt), 32'h0);
        chk("rst_trig", 32'(trig), 32'h0);
        cycle(); cycle();

        // 2: latency of a single transfer, then full-rate streaming
        send(8'hFF, 8'h00, 8'h00);
        #1 chk("lat_c1", 32'(out_valid), 32'h0);
        cycle();
        #1 chk("lat_c2", 32'(out_valid), 32'h1);
        chk("lat_out", 32'(out), 32'hFF);
        repeat (3) cycle();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; a = 8'(k * 37); b = 8'(k * 11); c = 8'(k * 5);
            #1 if (k >= 2) chk("tput", 32'(out_valid), 32'h1);
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // table-driven single transfers
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c);
            cycle();
            #1;
            chk("tbl_valid", 32'(out_valid), 32'h1);
            chk("tbl_out", 32'(out), 32'(vecs[i].exp));
        end
        repeat (2) cycle();

        // 3: four all-zero results raise trig, nonzero result clears the run
        reset_dut();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(8'h00, (k == 4) ? 8'hFF : 8'h00, 8'h00);
        cycle();
        #1;
        chk("run4_cnt", 32'(run_cnt), 32'h4);
        chk("run4_trig", 32'(trig), 32'h1);
        chk("sat_cnt2", 32'(run_cnt2), 32'h3);
        chk("sat_trig2", 32'(trig2), 32'h1);
        cycle();
        #1;
        chk("break_cnt", 32'(run_cnt), 32'h0);
        chk("sticky_trig", 32'(trig), 32'h1);
        repeat (2) cycle();

        // 5: trig_clr coinciding with an all-zero handshake
        reset_dut();
        for (int k = 0; k < 5; k++) send(8'h00, 8'h00, 8'h00);
        cycle();
        #1 chk("pre_clr_trig", 32'(trig), 32'h1);
        trig_clr = 1'b1;
        cycle();
        trig_clr = 1'b0;
        #1;
        chk("clr_cnt", 32'(run_cnt), 32'h0);
        chk("clr_trig", 32'(trig), 32'h0);
        chk("clr_cnt2", 32'(run_cnt2), 32'h0);
        cycle();

        // 4: full pipeline stalled for 5 cycles, then released
        reset_dut();
        out_ready = 1'b0;
        send(8'h00, 8'hFF, 8'h00);
        send(8'hFF, 8'hFF, 8'hFF);
        #1 saved = out;
        chk("stall_first", 32'(saved), 32'hFF);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = 8'h00; b = 8'h00; c = 8'h00;
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_out", 32'(out), 32'(saved));
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();

        // 6: reset during a stalled full pipeline
        out_ready = 1'b0;
        send(8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h00, 8'h00);
        repeat (2) cycle();
        reset_dut();
        #1;
        chk("rst6_valid", 32'(out_valid), 32'h0);
        chk("rst6_out", 32'(out), 32'hFF);
        chk("rst6_cnt", 32'(run_cnt), 32'h0);
        chk("rst6_trig", 32'(trig), 32'h0);
        out_ready = 1'b1;
        cycle();

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            trig_clr  = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 1) == 0) begin
                a = 8'h00; b = 8'h00; c = 8'($urandom);
            end else begin
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            end
            cycle();
        end
        rst = 1'b0; trig_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
